// File: rtl/extend_pkg.sv
// extend_pkg: shared mode encodings and widths for the immediate-extension unit.
package extend_pkg;
  localparam int IMM_W = 12;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    IMM_ZERO = 2'b00,
    IMM_ROT  = 2'b01,
    IMM_SIGN = 2'b10,
    IMM_WORD = 2'b11
  } imm_src_t;
endpackage

// File: rtl/extend_imm_comb.sv
// extend_imm_comb: combinational mode mux and ARM rotated-immediate decoder.
module extend_imm_comb
  import extend_pkg::*;
(
  input  logic [IMM_W-1:0]  immediate,
  input  logic [1:0]        imm_src,
  output logic [DATA_W-1:0] ext_imm
);
  logic [DATA_W-1:0] imm8;
  logic [4:0]        sh;
  logic [DATA_W-1:0] rot;
  assign imm8 = {24'h0, immediate[7:0]};
  assign sh = {immediate[11:8], 1'b0};
  // a left shift by 32 yields zero, so sh = 0 degenerates to a plain copy
  assign rot = (imm8 >> sh) | (imm8 << (6'd32 - {1'b0, sh}));
  assign ext_imm = imm_src == IMM_ZERO ? {20'h0, immediate} :
                   imm_src == IMM_ROT  ? rot :
                   imm_src == IMM_SIGN ? {{20{immediate[11]}}, immediate} :
                                         {{18{immediate[11]}}, immediate, 2'b00};
endmodule

// File: rtl/extend_imm.sv
// extend_imm: immediate extension with optional one-cycle output register.
module extend_imm
  import extend_pkg::*;
#(
  parameter bit REG_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [1:0]        imm_src,
  input  logic              in_valid,
  output logic [DATA_W-1:0] ext_imm,
  output logic              out_valid
);
  logic [DATA_W-1:0] f;
  logic [DATA_W-1:0] q;
  logic              v;
  extend_imm_comb u_comb (
    .immediate(immediate),
    .imm_src(imm_src),
    .ext_imm(f)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      v <= 1'b0;
    end else begin
      q <= in_valid ? f : q;
      v <= in_valid;
    end
  end
  assign ext_imm = REG_OUT ? q : f;
  assign out_valid = REG_OUT ? v : in_valid;
endmodule

// File: tb/tb_extend_imm.sv
// tb_extend_imm: directed checks of registered and combinational builds.
module tb_extend_imm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] immediate = '0;
  logic [1:0]  imm_src = '0;
  logic        in_valid = 1'b0;
  logic [31:0] ext_imm, ext_c;
  logic        out_valid, valid_c;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  extend_imm #(.REG_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .immediate(immediate), .imm_src(imm_src),
    .in_valid(in_valid), .ext_imm(ext_imm), .out_valid(out_valid)
  );
  extend_imm #(.REG_OUT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .immediate(immediate), .imm_src(imm_src),
    .in_valid(in_valid), .ext_imm(ext_c), .out_valid(valid_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [11:0] v_imm [6] = '{12'h4FF, 12'h1F3, 12'h0AB, 12'h800, 12'h7FF, 12'hFFF};
  logic [1:0]  v_src [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [31:0] v_exp [6] = '{32'hFF00_0000, 32'hC000_003C, 32'h0000_00AB,
                             32'hFFFF_F800, 32'h0000_07FF, 32'hFFFF_FFFC};

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_ext", ext_imm, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ext", ext_imm, 32'h0);
    check("post_rst_valid", {31'h0, out_valid}, 32'h0);
    immediate = 12'h078;
    imm_src = 2'b00;
    in_valid = 1'b1;
    #1;
    check("comb_zero", ext_c, 32'h0000_0078);
    check("comb_valid", {31'h0, valid_c}, 32'h1);
    @(negedge clk);
    check("zero_ext", ext_imm, 32'h0000_0078);
    check("zero_valid", {31'h0, out_valid}, 32'h1);
    in_valid = 1'b0;
    immediate = 12'hFFF;
    imm_src = 2'b10;
    #1;
    check("comb_follow", ext_c, 32'hFFFF_FFFF);
    check("comb_novalid", {31'h0, valid_c}, 32'h0);
    @(negedge clk);
    check("zero_hold", ext_imm, 32'h0000_0078);
    check("zero_drop", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      immediate = v_imm[i];
      imm_src = v_src[i];
      in_valid = 1'b1;
      #1;
      check($sformatf("comb_vec%0d", i), ext_c, v_exp[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), ext_imm, v_exp[i]);
      check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("last_hold", ext_imm, 32'hFFFF_FFFC);
    immediate = 12'h123;
    imm_src = 2'b00;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ext", ext_imm, 32'h0);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("rst_nocap_ext", ext_imm, 32'h0);
    check("rst_nocap_valid", {31'h0, out_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("resume_ext", ext_imm, 32'h0000_0123);
    check("resume_valid", {31'h0, out_valid}, 32'h1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
